// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read, write, debug and busy signals of the multi-port register file
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              busy;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [DATA_W-1:0] rd_data_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_2;
  logic              we_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              we_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_b;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    input  busy, rd_data_1, rd_data_2, dbg_data,
    output rd_addr_1, rd_addr_2, we_a, wr_addr_a, wr_data_a,
           we_b, wr_addr_b, wr_data_b, dbg_addr
  );

  modport slave (
    output busy, rd_data_1, rd_data_2, dbg_data,
    input  rd_addr_1, rd_addr_2, we_a, wr_addr_a, wr_data_a,
           we_b, wr_addr_b, wr_data_b, dbg_addr
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - 2R/2W register file with post-reset clear sweep and debug read port
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy_i;
  logic              wr_ok_a;
  logic              wr_ok_b;

  assign busy_i   = (state == CLEAR);
  assign bus.busy = busy_i;

  // Writes to the hardwired-zero entry are dropped so the array never holds a stale non-zero there.
  assign wr_ok_a = bus.we_a && !(ZERO_REG != 0 && bus.wr_addr_a == '0);
  assign wr_ok_b = bus.we_b && !(ZERO_REG != 0 && bus.wr_addr_b == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
      clr_idx      <= clr_idx + ADDR_W'(1);
      if (&clr_idx) begin
        state <= READY;
      end
    end else begin
      // Port B is assigned last so it wins an address collision.
      if (wr_ok_a) begin
        mem[bus.wr_addr_a] <= bus.wr_data_a;
      end
      if (wr_ok_b) begin
        mem[bus.wr_addr_b] <= bus.wr_data_b;
      end
    end
  end

  always_comb begin
    bus.rd_data_1 = mem[bus.rd_addr_1];
    bus.rd_data_2 = mem[bus.rd_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (bus.we_a && bus.wr_addr_a == bus.rd_addr_1) bus.rd_data_1 = bus.wr_data_a;
    if (bus.we_b && bus.wr_addr_b == bus.rd_addr_1) bus.rd_data_1 = bus.wr_data_b;
    if (bus.we_a && bus.wr_addr_a == bus.rd_addr_2) bus.rd_data_2 = bus.wr_data_a;
    if (bus.we_b && bus.wr_addr_b == bus.rd_addr_2) bus.rd_data_2 = bus.wr_data_b;
`else
`endif
    if (busy_i || (ZERO_REG != 0 && bus.rd_addr_1 == '0)) bus.rd_data_1 = '0;
    if (busy_i || (ZERO_REG != 0 && bus.rd_addr_2 == '0)) bus.rd_data_2 = '0;
  end

  always_comb begin
    bus.dbg_data = mem[bus.dbg_addr];
    if (busy_i || (ZERO_REG != 0 && bus.dbg_addr == '0)) bus.dbg_data = '0;
  end
endmodule
